// File: rtl/bcd_convert_seq_if.sv
// Handshake and result bundle between a binary source and the BCD converter.
// The source drives start/bin_in; the converter drives status and the held result.
interface bcd_convert_seq_if #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
    logic [DIGITS-1:0]     lz_mask;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow, lz_mask
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow, lz_mask
    );
endinterface

// File: rtl/bcd_convert_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with overflow saturate/truncate and a leading-zero blanking mask.
module bcd_convert_seq #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4,
    parameter bit          SAT    = 1'b1
) (
    input logic              clk,
    input logic              RSTN,
    bcd_convert_seq_if.slave bus
);
    localparam int unsigned INT_D = (BIN_W + 2) / 3;
    localparam int unsigned SCR_W = 4 * INT_D;
    localparam int unsigned PAD_D = (INT_D > DIGITS) ? INT_D : DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

    state_e                state_q, state_d;
    logic [BIN_W-1:0]      shift_q, shift_d;
    logic [SCR_W-1:0]      scr_q, scr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic [DIGITS-1:0]     lz_q, lz_d;

    logic [SCR_W-1:0]      adj;
    logic [4*PAD_D-1:0]    scr_pad;
    logic [4*PAD_D-1:0]    scr_hi;
    logic                  ovf_c;
    logic [4*DIGITS-1:0]   bcd_c;
    logic [DIGITS-1:0]     lz_c;
    logic                  nz;

    // Result candidates; scratch is zero-padded so DIGITS may exceed INT_D.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < int'(INT_D); i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
        scr_pad = '0;
        scr_pad[SCR_W-1:0] = scr_q;
        scr_hi = scr_pad >> (4 * DIGITS);
        ovf_c = |scr_hi;
        bcd_c = (ovf_c && SAT) ? {DIGITS{4'h9}} : scr_pad[4*DIGITS-1:0];
        lz_c = '0;
        nz = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            nz = nz | (bcd_c[4*i +: 4] != 4'h0);
            lz_c[i] = ~nz;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        lz_d    = lz_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    shift_d = bus.bin_in;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    busy_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                {scr_d, shift_d} = {adj[SCR_W-2:0], shift_q, 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = StLoad;
            end
            StLoad: begin
                bcd_d   = bcd_c;
                ovf_d   = ovf_c;
                lz_d    = lz_c;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_q <= StIdle;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            lz_q    <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            lz_q    <= lz_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;
    assign bus.lz_mask  = lz_q;
endmodule

// File: tb/tb_bcd_convert_seq.sv
// Scoreboard bench: three converter configurations driven in lockstep,
// expectations queued at start, checked by a monitor on each done pulse.
module tb_bcd_convert_seq;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [11:0] bin_in;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic [15:0] b0; logic [3:0] l0;
        logic [11:0] b1; logic o1; logic [2:0] l1;
        logic [11:0] b2; logic o2; logic [2:0] l2;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   bc0 = 0, bc1 = 0, bc2 = 0;

    bcd_convert_seq_if #(.BIN_W(12), .DIGITS(4)) bus0 ();
    bcd_convert_seq_if #(.BIN_W(12), .DIGITS(3)) bus1 ();
    bcd_convert_seq_if #(.BIN_W(12), .DIGITS(3)) bus2 ();

    assign bus0.start = start;  assign bus0.bin_in = bin_in;
    assign bus1.start = start;  assign bus1.bin_in = bin_in;
    assign bus2.start = start;  assign bus2.bin_in = bin_in;

    bcd_convert_seq #(.BIN_W(12), .DIGITS(4), .SAT(1'b1)) u_d4 (.clk(clk), .RSTN(rstn), .bus(bus0));
    bcd_convert_seq #(.BIN_W(12), .DIGITS(3), .SAT(1'b1)) u_d3s (.clk(clk), .RSTN(rstn), .bus(bus1));
    bcd_convert_seq #(.BIN_W(12), .DIGITS(3), .SAT(1'b0)) u_d3t (.clk(clk), .RSTN(rstn), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hand-computed results: D4/SAT, D3/SAT, D3/truncate.
    function automatic exp_t mk(input int v);
        exp_t x;
        x.acc = 0;
        case (v)
            3215: begin x.b0 = 16'h3215; x.l0 = 4'b0000; x.b1 = 12'h999; x.o1 = 1; x.l1 = 3'b000;
                        x.b2 = 12'h215; x.o2 = 1; x.l2 = 3'b000; end
            0:    begin x.b0 = 16'h0000; x.l0 = 4'b1110; x.b1 = 12'h000; x.o1 = 0; x.l1 = 3'b110;
                        x.b2 = 12'h000; x.o2 = 0; x.l2 = 3'b110; end
            4095: begin x.b0 = 16'h4095; x.l0 = 4'b0000; x.b1 = 12'h999; x.o1 = 1; x.l1 = 3'b000;
                        x.b2 = 12'h095; x.o2 = 1; x.l2 = 3'b100; end
            7:    begin x.b0 = 16'h0007; x.l0 = 4'b1110; x.b1 = 12'h007; x.o1 = 0; x.l1 = 3'b110;
                        x.b2 = 12'h007; x.o2 = 0; x.l2 = 3'b110; end
            999:  begin x.b0 = 16'h0999; x.l0 = 4'b1000; x.b1 = 12'h999; x.o1 = 0; x.l1 = 3'b000;
                        x.b2 = 12'h999; x.o2 = 0; x.l2 = 3'b000; end
            1000: begin x.b0 = 16'h1000; x.l0 = 4'b0000; x.b1 = 12'h999; x.o1 = 1; x.l1 = 3'b000;
                        x.b2 = 12'h000; x.o2 = 1; x.l2 = 3'b110; end
            default: begin x.b0 = 16'h1123; x.l0 = 4'b0000; x.b1 = 12'h999; x.o1 = 1;
                        x.l1 = 3'b000; x.b2 = 12'h123; x.o2 = 1; x.l2 = 3'b000; end
        endcase
        return x;
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            bc0 = 0; bc1 = 0; bc2 = 0;
        end else begin
            bc0 += int'(bus0.busy); bc1 += int'(bus1.busy); bc2 += int'(bus2.busy);
            if (bus0.done || bus1.done || bus2.done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("done_all", {29'd0, bus0.done, bus1.done, bus2.done}, 32'd7);
                    check("latency", cyc - e.acc, 32'd13);
                    check("busy_cycles_d4", bc0, 32'd13);
                    check("busy_cycles_d3s", bc1, 32'd13);
                    check("busy_cycles_d3t", bc2, 32'd13);
                    check("bcd_d4", 32'(bus0.bcd_out), 32'(e.b0));
                    check("ovf_d4", 32'(bus0.overflow), 32'd0);
                    check("lz_d4", 32'(bus0.lz_mask), 32'(e.l0));
                    check("bcd_d3s", 32'(bus1.bcd_out), 32'(e.b1));
                    check("ovf_d3s", 32'(bus1.overflow), 32'(e.o1));
                    check("lz_d3s", 32'(bus1.lz_mask), 32'(e.l1));
                    check("bcd_d3t", 32'(bus2.bcd_out), 32'(e.b2));
                    check("ovf_d3t", 32'(bus2.overflow), 32'(e.o2));
                    check("lz_d3t", 32'(bus2.lz_mask), 32'(e.l2));
                end
                bc0 = 0; bc1 = 0; bc2 = 0;
            end
        end
    end

    task automatic convert(input int v);
        exp_t x;
        x = mk(v);
        @(negedge clk);
        bin_in = 12'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        x.acc = cyc;
        q.push_back(x);
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'({bus0.busy, bus1.busy, bus2.busy}), 32'd0);
        check({tag, "_done"}, 32'({bus0.done, bus1.done, bus2.done}), 32'd0);
        check({tag, "_bcd_d4"}, 32'(bus0.bcd_out), 32'd0);
        check({tag, "_bcd_d3"}, 32'({bus1.bcd_out, bus2.bcd_out}), 32'd0);
        check({tag, "_ovf"}, 32'({bus0.overflow, bus1.overflow, bus2.overflow}), 32'd0);
        check({tag, "_lz"}, 32'({bus0.lz_mask, bus1.lz_mask, bus2.lz_mask}), 32'd0);
    endtask

    int   a;
    exp_t x;
    int   vecs[6] = '{3215, 0, 4095, 7, 999, 1000};

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rstn = 1'b1;

        foreach (vecs[i]) convert(vecs[i]);

        // Start while busy is ignored; start held through done is accepted.
        x = mk(3215);
        @(negedge clk);
        bin_in = 12'd3215;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        x.acc = a;
        q.push_back(x);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        bin_in = 12'd1123;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        x = mk(1123);
        x.acc = a + 14;
        q.push_back(x);
        repeat (8) @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);

        // Reset mid-conversion aborts with outputs cleared and no done.
        @(negedge clk);
        bin_in = 12'd3215;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_cleared("abort");
        rstn = 1'b1;
        repeat (16) @(negedge clk);
        convert(1123);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
